// File: rtl/comparador_pkg.sv
// Shared encodings for the sequential comparator: relation modes, FSM states
// and the relation flags bundle, plus the mode-to-result evaluation.
package comparador_pkg;

    typedef enum logic [2:0] {
        MODO_EQ   = 3'b000,
        MODO_NE   = 3'b001,
        MODO_LT   = 3'b010,
        MODO_LE   = 3'b011,
        MODO_GT   = 3'b100,
        MODO_GE   = 3'b101,
        MODO_RES6 = 3'b110,
        MODO_RES7 = 3'b111
    } modo_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    typedef struct packed {
        logic igual;
        logic diferente;
        logic menor;
        logic maior;
    } flags_t;

    // Reserved encodings evaluate to false; the flags stay meaningful regardless.
    function automatic logic avalia(input modo_t m, input flags_t f);
        logic r;
        r = 1'b0;
        case (m)
            MODO_EQ: r = f.igual;
            MODO_NE: r = f.diferente;
            MODO_LT: r = f.menor;
            MODO_LE: r = f.menor | f.igual;
            MODO_GT: r = f.maior;
            MODO_GE: r = f.maior | f.igual;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/comparador_sequencial_if.sv
// Request/response bundle of the sequential comparator: operands and mode in,
// busy/done handshake plus result and relation flags out.
interface comparador_sequencial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       modo;
    logic             sinal;
    logic             busy;
    logic             done;
    logic             resultado;
    logic             igual;
    logic             diferente;
    logic             menor;
    logic             maior;

    modport master (
        output start, a, b, modo, sinal,
        input  busy, done, resultado, igual, diferente, menor, maior
    );

    modport slave (
        input  start, a, b, modo, sinal,
        output busy, done, resultado, igual, diferente, menor, maior
    );
endinterface

// File: rtl/comparador_fatia.sv
// Combinational compare of one CHUNK-bit slice. With com_sinal set the slice
// is the operand's top slice, so differing sign bits decide the order.
module comparador_fatia #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             com_sinal,
    output logic             eq,
    output logic             lt
);

    always_comb begin
        eq = (x == y);
        lt = (x < y);
        // Negative operand is smaller, even though its slice is larger unsigned.
        if (com_sinal && (x[CHUNK-1] != y[CHUNK-1])) begin
            lt = x[CHUNK-1];
        end
    end

endmodule

// File: rtl/comparador_sequencial.sv
// Sequential magnitude comparator: walks the latched operands one slice per
// cycle from the most significant end and stops at the first differing slice.
module comparador_sequencial
    import comparador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    comparador_sequencial_if.slave  bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_TOPO = IDX_W'(N - 1);

    estado_t          estado_reg, estado_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    modo_t            modo_reg, modo_next;
    logic             sinal_reg, sinal_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    flags_t           flags_reg, flags_next;
    logic             resultado_reg, resultado_next;

    logic [CHUNK-1:0] fatias_a [N];
    logic [CHUNK-1:0] fatias_b [N];
    logic [CHUNK-1:0] fatia_a, fatia_b;
    logic             fatia_com_sinal;
    logic             fatia_eq, fatia_lt;
    flags_t           flags_dif, flags_igual;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fatia
            assign fatias_a[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign fatias_b[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign fatia_a         = fatias_a[idx_reg];
    assign fatia_b         = fatias_b[idx_reg];
    assign fatia_com_sinal = sinal_reg && (idx_reg == IDX_TOPO);

    comparador_fatia #(
        .CHUNK (CHUNK)
    ) u_fatia (
        .x         (fatia_a),
        .y         (fatia_b),
        .com_sinal (fatia_com_sinal),
        .eq        (fatia_eq),
        .lt        (fatia_lt)
    );

    always_comb begin
        flags_dif.igual     = 1'b0;
        flags_dif.diferente = 1'b1;
        flags_dif.menor     = fatia_lt;
        flags_dif.maior     = ~fatia_lt;

        flags_igual.igual     = 1'b1;
        flags_igual.diferente = 1'b0;
        flags_igual.menor     = 1'b0;
        flags_igual.maior     = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg    <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            modo_reg      <= MODO_EQ;
            sinal_reg     <= 1'b0;
            idx_reg       <= '0;
            flags_reg     <= '0;
            resultado_reg <= 1'b0;
        end else begin
            estado_reg    <= estado_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            modo_reg      <= modo_next;
            sinal_reg     <= sinal_next;
            idx_reg       <= idx_next;
            flags_reg     <= flags_next;
            resultado_reg <= resultado_next;
        end
    end

    always_comb begin
        estado_next    = estado_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        modo_next      = modo_reg;
        sinal_next     = sinal_reg;
        idx_next       = idx_reg;
        flags_next     = flags_reg;
        resultado_next = resultado_reg;

        case (estado_reg)
            IDLE: begin
                if (bus.start) begin
                    a_next      = bus.a;
                    b_next      = bus.b;
                    modo_next   = modo_t'(bus.modo);
                    sinal_next  = bus.sinal;
                    idx_next    = IDX_TOPO;
                    estado_next = COMPARA;
                end
            end
            COMPARA: begin
                // First differing slice settles the order; lower slices are irrelevant.
                if (!fatia_eq) begin
                    flags_next     = flags_dif;
                    resultado_next = avalia(modo_reg, flags_dif);
                    estado_next    = FIM;
                end else if (idx_reg == '0) begin
                    flags_next     = flags_igual;
                    resultado_next = avalia(modo_reg, flags_igual);
                    estado_next    = FIM;
                end else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
            end
            FIM: begin
                estado_next = IDLE;
            end
            default: begin
                estado_next = IDLE;
            end
        endcase
    end

    assign bus.busy      = (estado_reg == COMPARA);
    assign bus.done      = (estado_reg == FIM);
    assign bus.resultado = resultado_reg;
    assign bus.igual     = flags_reg.igual;
    assign bus.diferente = flags_reg.diferente;
    assign bus.menor     = flags_reg.menor;
    assign bus.maior     = flags_reg.maior;

endmodule

// File: tb/tb_comparador_sequencial.sv
// Bench for comparador_sequencial: table of hand-derived vectors, random vectors
// against a behavioural model, and hand sequences for busy/reset/held-start cases.
module tb_comparador_sequencial;
    import comparador_pkg::*;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       modo;
        logic             sinal;
        int               lat;
        logic             igual;
        logic             diferente;
        logic             menor;
        logic             maior;
        logic             res;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tabela[13];

    always #5 clock = ~clock;

    comparador_sequencial_if #(.WIDTH(WIDTH)) bus ();

    comparador_sequencial #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [2:0] m, input logic s, input int lat,
                                input logic ig, input logic df, input logic me,
                                input logic ma, input logic r);
        vec_t v;
        v.a = a; v.b = b; v.modo = m; v.sinal = s; v.lat = lat;
        v.igual = ig; v.diferente = df; v.menor = me; v.maior = ma; v.res = r;
        return v;
    endfunction

    // Behavioural reference: whole-word compare plus first-differing-slice latency.
    function automatic vec_t modelo(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [2:0] m, input logic s);
        vec_t v;
        logic lt, gt, eq, achou;
        eq = (a == b);
        lt = s ? ($signed(a) < $signed(b)) : (a < b);
        gt = s ? ($signed(a) > $signed(b)) : (a > b);
        v.a = a; v.b = b; v.modo = m; v.sinal = s;
        v.igual = eq; v.diferente = !eq; v.menor = lt; v.maior = gt;
        v.lat = N;
        achou = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!achou && (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK])) begin
                v.lat = N - i;
                achou = 1'b1;
            end
        end
        case (m)
            3'b000:  v.res = eq;
            3'b001:  v.res = !eq;
            3'b010:  v.res = lt;
            3'b011:  v.res = lt || eq;
            3'b100:  v.res = gt;
            3'b101:  v.res = gt || eq;
            default: v.res = 1'b0;
        endcase
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.a     = v.a;
        bus.b     = v.b;
        bus.modo  = v.modo;
        bus.sinal = v.sinal;
        bus.start = 1'b1;
        sb.push_back(v);
    endtask

    // Counts negedges until done; k=1 means done in the cycle after the start edge.
    task automatic wait_done(output int k, output bit got);
        k   = 0;
        got = 1'b0;
        while (k < 20 && !got) begin
            @(negedge clock);
            k++;
            if (bus.done) got = 1'b1;
        end
    endtask

    task automatic check_done(input bit got, input int k);
        vec_t  e;
        string id;
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e  = sb.pop_front();
        id = $sformatf("a=%h b=%h modo=%0d s=%0b", e.a, e.b, e.modo, e.sinal);
        chk({"done_seen ", id}, got, 1);
        if (!got) return;
        chk({"latency ", id},   k,             e.lat);
        chk({"igual ", id},     bus.igual,     e.igual);
        chk({"diferente ", id}, bus.diferente, e.diferente);
        chk({"menor ", id},     bus.menor,     e.menor);
        chk({"maior ", id},     bus.maior,     e.maior);
        chk({"resultado ", id}, bus.resultado, e.res);
        chk({"busy_in_fim ", id}, bus.busy,    0);
    endtask

    task automatic run(input vec_t v);
        int k;
        bit got;
        @(negedge clock);
        drive(v);
        @(negedge clock);
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        wait_done(k, got);
        check_done(got, k);
        @(negedge clock);
        chk("done_one_cycle", bus.done, 0);
        chk("busy_after_fim", bus.busy, 0);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k, cnt;
        bit   got;
        vec_t v;
        logic [WIDTH-1:0] ra, rb;

        tabela[0]  = mk(16'h1234, 16'h1234, 3'b000, 0, 4, 1, 0, 0, 0, 1);
        tabela[1]  = mk(16'h8000, 16'h7FFF, 3'b100, 0, 1, 0, 1, 0, 1, 1);
        tabela[2]  = mk(16'h8000, 16'h7FFF, 3'b100, 1, 1, 0, 1, 1, 0, 0);
        tabela[3]  = mk(16'h00F1, 16'h00F0, 3'b001, 0, 4, 0, 1, 0, 1, 1);
        tabela[4]  = mk(16'h0003, 16'h0001, 3'b110, 0, 4, 0, 1, 0, 1, 0);
        tabela[5]  = mk(16'hFFFF, 16'hFFFF, 3'b101, 1, 4, 1, 0, 0, 0, 1);
        tabela[6]  = mk(16'h0001, 16'h0002, 3'b010, 0, 4, 0, 1, 1, 0, 1);
        tabela[7]  = mk(16'hFFFE, 16'h0001, 3'b010, 1, 1, 0, 1, 1, 0, 1);
        tabela[8]  = mk(16'hFFFE, 16'hFFFF, 3'b011, 1, 4, 0, 1, 1, 0, 1);
        tabela[9]  = mk(16'h1200, 16'h1300, 3'b101, 0, 2, 0, 1, 1, 0, 0);
        tabela[10] = mk(16'h0005, 16'h0005, 3'b111, 0, 4, 1, 0, 0, 0, 0);
        tabela[11] = mk(16'h7FFF, 16'h8000, 3'b011, 1, 1, 0, 1, 0, 1, 0);
        tabela[12] = mk(16'hA5A5, 16'hA5C5, 3'b100, 0, 3, 0, 1, 1, 0, 0);

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.modo  = '0;
        bus.sinal = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_resultado", bus.resultado, 0);
        chk("rst_flags", {bus.igual, bus.diferente, bus.menor, bus.maior}, 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run(tabela[i]);
        end

        // Results hold after done until the next comparison ends.
        repeat (3) @(negedge clock);
        chk("hold_flags", {bus.igual, bus.diferente, bus.menor, bus.maior}, 4'b0110);
        chk("hold_resultado", bus.resultado, 0);

        for (int i = 0; i < 16; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 2 == 0) ? ra ^ WIDTH'(($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)))
                              : WIDTH'($urandom);
            run(modelo(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))));
        end

        // Second start while busy (with new operands) must be ignored.
        @(negedge clock);
        drive(mk(16'h0001, 16'h0002, 3'b010, 0, 4, 0, 1, 1, 0, 1));
        @(negedge clock);
        bus.a    = 16'h0005;
        bus.b    = 16'h0005;
        bus.modo = 3'b000;
        chk("busy_ignore_start", bus.busy, 1);
        wait_done(k, got);
        bus.start = 1'b0;
        check_done(got, k);
        count_done(6, cnt);
        chk("no_extra_done", cnt, 0);

        // Reset two cycles into a comparison aborts it without a done pulse.
        @(negedge clock);
        drive(mk(16'h0001, 16'h0002, 3'b010, 0, 4, 0, 1, 1, 0, 1));
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_resultado", bus.resultado, 0);
        chk("abort_flags", {bus.igual, bus.diferente, bus.menor, bus.maior}, 0);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        count_done(6, cnt);
        chk("abort_no_done", cnt, 0);
        run(mk(16'hFFFF, 16'hFFFF, 3'b101, 0, 4, 1, 0, 0, 0, 1));

        // Start held high relaunches on each return to IDLE.
        @(negedge clock);
        drive(mk(16'h8000, 16'h7FFF, 3'b100, 0, 1, 0, 1, 0, 1, 1));
        @(negedge clock);
        wait_done(k, got);
        check_done(got, k);
        drive(mk(16'hFFFE, 16'h0001, 3'b010, 1, 1, 0, 1, 1, 0, 1));
        @(negedge clock);
        chk("held_idle_gap", bus.busy, 0);
        @(negedge clock);
        chk("held_relaunch", bus.busy, 1);
        wait_done(k, got);
        bus.start = 1'b0;
        check_done(got, k);
        @(negedge clock);
        chk("held_done_one_cycle", bus.done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparador_sequencial.md
COMPARADOR_SEQUENCIAL -- requirements
Module: comparador_sequencial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; WIDTH SHALL be a multiple of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per clock cycle; N = WIDTH/CHUNK slices.
REQ-003 clock  input  1  single clock, all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a comparison; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A, latched at start.
REQ-007 b  input  WIDTH  operand B, latched at start.
REQ-008 modo  input  3  relation select, latched at start: 000 EQ, 001 NE, 010 LT, 011 LE, 100 GT, 101 GE, 110/111 reserved.
REQ-009 sinal  input  1  1 = two's-complement compare, 0 = unsigned; latched at start.
REQ-010 busy  output  1  high while a comparison is in progress.
REQ-011 done  output  1  one-cycle pulse when result and flags become valid.
REQ-012 resultado  output  1  truth value of the selected relation.
REQ-013 igual, diferente, menor, maior  output  1 each  A==B, A!=B, A<B, A>B.

Function
REQ-014 FSM states SHALL be IDLE, COMPARA, FIM; reset state IDLE.
REQ-015 IDLE with start=1 at an edge: latch a, b, modo, sinal; slice index := N-1; go to COMPARA; busy=1 from that edge.
REQ-016 COMPARA SHALL compare one CHUNK-bit slice per cycle, MSB slice first, index decrementing.
REQ-017 If the current slice differs, the FSM SHALL decide A<B or A>B from that slice and go to FIM (early termination).
REQ-018 If the slice is equal and index==0, operands are equal; go to FIM.
REQ-019 Signed mode, MSB slice only: if sign bits differ, operand with sign bit 1 is smaller; otherwise unsigned slice compare applies.
REQ-020 Entering FIM SHALL register flags and resultado; done=1 and busy=0 for exactly the FIM cycle; next state IDLE.
REQ-021 Latency: done high k cycles after the start-sampling edge, k = slices examined (1..N); equal operands give k=N.
REQ-022 Exactly one of igual/diferente and at most one of menor/maior SHALL be 1 when valid.
REQ-023 Reserved modo SHALL give resultado=0; flags remain correct.
REQ-024 Flags and resultado SHALL hold their value after done until the next FIM.
REQ-025 start while busy or in FIM SHALL be ignored; latched operands are unaffected by input changes.
REQ-026 start held high continuously SHALL launch a new comparison on each return to IDLE.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, busy=0, done=0, resultado=0, all four flags 0, latched operands 0.
REQ-028 Reset during COMPARA or FIM SHALL abort with no done pulse; first start after release behaves per REQ-015.

Structure
REQ-029 Mode encodings and state encodings SHALL live in a shared package comparador_pkg.
REQ-030 A combinational sub-module comparador_fatia (CHUNK-bit slice: outputs eq, lt; input sign-aware flag) SHALL perform per-slice comparison.

Verification
REQ-031 a=b=16'h1234, modo EQ, sinal 0 -> done 4 cycles after start, igual=1, resultado=1, menor=maior=0.
REQ-032 a=16'h8000, b=16'h7FFF, modo GT: sinal 0 -> maior=1, resultado=1, done after 1 cycle; sinal 1 -> menor=1, resultado=0, done after 1 cycle.
REQ-033 a=16'h00F1, b=16'h00F0, modo NE -> done after 4 cycles, diferente=1, maior=1, resultado=1.
REQ-034 start with a=16'h0001, b=16'h0002 (LT); second start during busy with a=b -> ignored, single done, menor=1, resultado=1.
REQ-035 reset asserted 2 cycles into a compare -> busy, done, flags 0 same cycle, no done pulse; subsequent a=b=16'hFFFF, GE -> resultado=1.
REQ-036 modo 110, a=16'h0003, b=16'h0001 -> resultado=0, maior=1, diferente=1.
